// File: rtl/uart_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_mem_ctrl_if
// Groups the UART receive/transmit handshake and the program-memory port of
// uart_mem_ctrl into one bundle.
//   valid_rx_i     : one-cycle pulse, serial_read_i holds a received byte
//   serial_read_i  : received UART byte
//   busy_tx_i      : UART transmitter busy
//   start_tx_o     : one-cycle pulse, transmit serial_write_o
//   serial_write_o : response byte
//   addr_o         : program-memory address (ADDR_W bits)
//   we_o           : program-memory write enable
//   data_o         : program-memory write data
//   q_i            : program-memory read data (one-cycle read latency)
//   busy_o         : controller not idle
//   err_o          : one-cycle pulse on NAK, dropped byte or timeout
// Modports: slave = controller view, master = environment (UART + memory).
// ---------------------------------------------------------------------------
interface uart_mem_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              valid_rx_i;
  logic [7:0]        serial_read_i;
  logic              busy_tx_i;
  logic              start_tx_o;
  logic [7:0]        serial_write_o;
  logic [ADDR_W-1:0] addr_o;
  logic              we_o;
  logic [7:0]        data_o;
  logic [7:0]        q_i;
  logic              busy_o;
  logic              err_o;

  modport slave (
    input  valid_rx_i, serial_read_i, busy_tx_i, q_i,
    output start_tx_o, serial_write_o, addr_o, we_o, data_o, busy_o, err_o
  );

  modport master (
    output valid_rx_i, serial_read_i, busy_tx_i, q_i,
    input  start_tx_o, serial_write_o, addr_o, we_o, data_o, busy_o, err_o
  );
endinterface

// File: rtl/uart_mem_ctrl.sv
// ---------------------------------------------------------------------------
// uart_mem_ctrl
// Byte-oriented UART command decoder giving read/write access to a program
// memory. Packets: write = 0x57, addr, data (answered with ACK 0x06);
// read = 0x52, addr (answered with the memory byte). Any other command byte
// is answered with NAK 0x15 and an err_o pulse.
// Ports:
//   CLK_UART_i : system clock, all logic on its rising edge
//   RST_N_i    : asynchronous active-low reset
//   bus        : uart_mem_ctrl_if.slave (UART handshake + memory port)
// Parameters:
//   ADDR_W      : memory address width (at most 8, taken from the addr byte)
//   TIMEOUT_CYC : inter-byte timeout in clocks (minimum 2)
// Optional feature macro: UART_MEM_CTRL_TIMEOUT_EN builds an inter-byte
// timeout counter that abandons a half-received packet. Without it the
// controller waits indefinitely for the address/data bytes.
// ---------------------------------------------------------------------------
module uart_mem_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 5208
) (
  input logic            CLK_UART_i,
  input logic            RST_N_i,
  uart_mem_ctrl_if.slave bus
);

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_GET_ADDR   = 4'd1;
  localparam logic [3:0] ST_GET_DATA   = 4'd2;
  localparam logic [3:0] ST_MEM_WR     = 4'd3;
  localparam logic [3:0] ST_MEM_RD     = 4'd4;
  localparam logic [3:0] ST_RD_WAIT    = 4'd5;
  localparam logic [3:0] ST_TX_REQ     = 4'd6;
  localparam logic [3:0] ST_TX_WAIT_HI = 4'd7;
  localparam logic [3:0] ST_TX_WAIT_LO = 4'd8;

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("uart_mem_ctrl: TIMEOUT_CYC must be at least 2");
  end
  if (ADDR_W > 8 || ADDR_W < 1) begin : g_bad_addr_w
    $error("uart_mem_ctrl: ADDR_W must be between 1 and 8");
  end

  logic [3:0]        state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        resp_q, resp_d;   // response waiting to be sent
  logic [7:0]        txd_q, txd_d;     // byte handed to the transmitter
  logic              start_q, start_d;
  logic              err_q, err_d;
  logic              in_rx_state;

`ifdef UART_MEM_CTRL_TIMEOUT_EN
  localparam int              TMO_W   = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  // States that accept a byte; everywhere else an incoming byte is dropped.
  assign in_rx_state = (state_q == ST_IDLE) || (state_q == ST_GET_ADDR) ||
                       (state_q == ST_GET_DATA);

  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    resp_d  = resp_q;
    txd_d   = txd_q;
    start_d = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.valid_rx_i) begin
          if (bus.serial_read_i == CMD_WR || bus.serial_read_i == CMD_RD) begin
            is_wr_d = (bus.serial_read_i == CMD_WR);
            state_d = ST_GET_ADDR;
          end else begin
            resp_d  = NAK;
            err_d   = 1'b1;
            state_d = ST_TX_REQ;
          end
        end
      end
      ST_GET_ADDR: begin
        if (bus.valid_rx_i) begin
          addr_d  = ADDR_W'(bus.serial_read_i);
          state_d = is_wr_q ? ST_GET_DATA : ST_MEM_RD;
        end
      end
      ST_GET_DATA: begin
        if (bus.valid_rx_i) begin
          data_d  = bus.serial_read_i;
          state_d = ST_MEM_WR;
        end
      end
      ST_MEM_WR: begin
        resp_d  = ACK;
        state_d = ST_TX_REQ;
      end
      // Address is presented during MEM_RD; q_i is valid in RD_WAIT.
      ST_MEM_RD:  state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        resp_d  = bus.q_i;
        state_d = ST_TX_REQ;
      end
      ST_TX_REQ: begin
        if (!bus.busy_tx_i) begin
          txd_d   = resp_q;
          start_d = 1'b1;
          state_d = ST_TX_WAIT_HI;
        end
      end
      ST_TX_WAIT_HI: if (bus.busy_tx_i)  state_d = ST_TX_WAIT_LO;
      ST_TX_WAIT_LO: if (!bus.busy_tx_i) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase

    // A byte arriving while busy is discarded; the state is unaffected by it.
    if (bus.valid_rx_i && !in_rx_state) err_d = 1'b1;

`ifdef UART_MEM_CTRL_TIMEOUT_EN
    // Counter restarts on every received byte and only runs while waiting
    // for the rest of a packet.
    tmo_d = '0;
    if ((state_q == ST_GET_ADDR || state_q == ST_GET_DATA) && !bus.valid_rx_i) begin
      if (tmo_q == TMO_MAX) begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge CLK_UART_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      state_q <= ST_IDLE;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      resp_q  <= '0;
      txd_q   <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef UART_MEM_CTRL_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      resp_q  <= resp_d;
      txd_q   <= txd_d;
      start_q <= start_d;
      err_q   <= err_d;
`ifdef UART_MEM_CTRL_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  // we_o and busy_o decode the state register directly so they follow the
  // asynchronous reset without an extra flop.
  assign bus.start_tx_o     = start_q;
  assign bus.serial_write_o = txd_q;
  assign bus.addr_o         = addr_q;
  assign bus.data_o         = data_q;
  assign bus.we_o           = (state_q == ST_MEM_WR);
  assign bus.busy_o         = (state_q != ST_IDLE);
  assign bus.err_o          = err_q;

endmodule

// File: tb/tb_uart_mem_ctrl.sv
module tb_uart_mem_ctrl;
  localparam int ADDR_W = 8;
  localparam int TMO    = 16;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  uart_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  uart_mem_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
    .CLK_UART_i (clk),
    .RST_N_i    (rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Program memory with one-cycle synchronous read.
  logic [7:0] mem [256];
  logic [7:0] mem_q;
  logic       mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (bus.we_o) begin
      mem[bus.addr_o] <= bus.data_o;
    end
    mem_q <= mem[bus.addr_o];
  end
  assign bus.q_i = mem_q;

  // UART transmitter: busy for 4 cycles after each start pulse.
  logic tx_busy_q;
  int   tx_cnt;
  logic hold_busy;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy_q <= 1'b0;
      tx_cnt    <= 0;
    end else if (bus.start_tx_o) begin
      tx_busy_q <= 1'b1;
      tx_cnt    <= 4;
    end else if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) tx_busy_q <= 1'b0;
    end
  end
  assign bus.busy_tx_i = tx_busy_q | hold_busy;

  // Reference model: the memory contents implied by the packets sent so far.
  logic [7:0] ref_mem [256];

  // Event monitor
  logic [7:0] we_addr_q[$];
  logic [7:0] we_data_q[$];
  int         we_cyc_q[$];
  logic [7:0] st_val_q[$];
  int         st_cyc_q[$];
  int         err_n;
  always @(negedge clk) begin
    if (bus.we_o) begin
      we_addr_q.push_back(bus.addr_o);
      we_data_q.push_back(bus.data_o);
      we_cyc_q.push_back(cyc);
    end
    if (bus.start_tx_o) begin
      st_val_q.push_back(bus.serial_write_o);
      st_cyc_q.push_back(cyc);
    end
    if (bus.err_o) err_n = err_n + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time expired, required finish before 500000");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    we_addr_q.delete(); we_data_q.delete(); we_cyc_q.delete();
    st_val_q.delete();  st_cyc_q.delete();
    err_n = 0;
  endtask

  // Drives one byte for one cycle; e is the clock edge that samples it.
  task automatic send_byte(input logic [7:0] b, output int e);
    @(negedge clk);
    bus.valid_rx_i    = 1'b1;
    bus.serial_read_i = b;
    e = cyc + 1;
    @(negedge clk);
    bus.valid_rx_i    = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!bus.busy_o && !bus.busy_tx_i) begin ok = 1; break; end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s_idle: busy_o=%b still high, required 0 within 400 cycles", name, bus.busy_o);
    end
  endtask

  task automatic do_write(input string name, input logic [7:0] a, input logic [7:0] d);
    int e0, e1, e2;
    clear_mon();
    send_byte(8'h57, e0);
    send_byte(a, e1);
    send_byte(d, e2);
    wait_idle(name);
    ref_mem[a] = d;
    n_cmp++;
    if (we_addr_q.size() != 1) begin
      n_bad++;
      $display("FAIL %s_we_count: got %0d pulses, required 1", name, we_addr_q.size());
    end else begin
      n_cmp++;
      if (we_addr_q[0] !== a) begin n_bad++; $display("FAIL %s_we_addr: got %h required %h", name, we_addr_q[0], a); end
      n_cmp++;
      if (we_data_q[0] !== d) begin n_bad++; $display("FAIL %s_we_data: got %h required %h", name, we_data_q[0], d); end
      n_cmp++;
      if (we_cyc_q[0] != e2) begin n_bad++; $display("FAIL %s_we_latency: got cycle %0d required %0d", name, we_cyc_q[0], e2); end
    end
    n_cmp++;
    if (st_val_q.size() != 1) begin
      n_bad++;
      $display("FAIL %s_start_count: got %0d pulses, required 1", name, st_val_q.size());
    end else begin
      n_cmp++;
      if (st_val_q[0] !== 8'h06) begin n_bad++; $display("FAIL %s_ack: got %h required 06", name, st_val_q[0]); end
      n_cmp++;
      if (st_cyc_q[0] != e2 + 2) begin n_bad++; $display("FAIL %s_ack_latency: got cycle %0d required %0d", name, st_cyc_q[0], e2 + 2); end
    end
    n_cmp++;
    if (err_n != 0) begin n_bad++; $display("FAIL %s_err: got %0d pulses required 0", name, err_n); end
    $display("write %s addr=%h data=%h", name, a, d);
  endtask

  task automatic do_read(input string name, input logic [7:0] a);
    int e0, e1;
    clear_mon();
    send_byte(8'h52, e0);
    send_byte(a, e1);
    wait_idle(name);
    n_cmp++;
    if (we_addr_q.size() != 0) begin n_bad++; $display("FAIL %s_we_during_read: got %0d pulses required 0", name, we_addr_q.size()); end
    n_cmp++;
    if (st_val_q.size() != 1) begin
      n_bad++;
      $display("FAIL %s_start_count: got %0d pulses, required 1", name, st_val_q.size());
    end else begin
      n_cmp++;
      if (st_val_q[0] !== ref_mem[a]) begin n_bad++; $display("FAIL %s_rdata: got %h required %h", name, st_val_q[0], ref_mem[a]); end
      n_cmp++;
      if (st_cyc_q[0] != e1 + 3) begin n_bad++; $display("FAIL %s_rd_latency: got cycle %0d required %0d", name, st_cyc_q[0], e1 + 3); end
    end
    n_cmp++;
    if (err_n != 0) begin n_bad++; $display("FAIL %s_err: got %0d pulses required 0", name, err_n); end
    $display("read  %s addr=%h expect=%h", name, a, ref_mem[a]);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; hold_busy = 1'b0; mem_clr = 1'b1;
    bus.valid_rx_i = 1'b0; bus.serial_read_i = 8'h00;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.busy_o !== 1'b0)         begin n_bad++; $display("FAIL reset_busy: got %b required 0", bus.busy_o); end
    n_cmp++; if (bus.we_o !== 1'b0)           begin n_bad++; $display("FAIL reset_we: got %b required 0", bus.we_o); end
    n_cmp++; if (bus.start_tx_o !== 1'b0)     begin n_bad++; $display("FAIL reset_start: got %b required 0", bus.start_tx_o); end
    n_cmp++; if (bus.err_o !== 1'b0)          begin n_bad++; $display("FAIL reset_err: got %b required 0", bus.err_o); end
    n_cmp++; if (bus.addr_o !== '0)           begin n_bad++; $display("FAIL reset_addr: got %h required 00", bus.addr_o); end
    n_cmp++; if (bus.data_o !== 8'h00)        begin n_bad++; $display("FAIL reset_data: got %h required 00", bus.data_o); end
    n_cmp++; if (bus.serial_write_o !== 8'h00) begin n_bad++; $display("FAIL reset_txd: got %h required 00", bus.serial_write_o); end
    repeat (3) @(negedge clk);
    mem_clr = 1'b0;
    rst_n   = 1'b1;
    repeat (2) @(negedge clk);
    $display("reset checked");
  endtask

  task automatic test_write_read();
    do_write("wr_a5", 8'h10, 8'hA5);
    do_write("wr_3c", 8'h10, 8'h3C);
    do_read("rd_3c", 8'h10);
    do_write("wr_ff", 8'hFF, 8'h81);
    do_read("rd_ff", 8'hFF);
    do_read("rd_00_init", 8'h00);
  endtask

  task automatic test_nak();
    logic [7:0] bad [4];
    int e;
    bad[0] = 8'h41;
    for (int i = 1; i < 4; i++) begin
      bad[i] = 8'($urandom_range(0, 255));
      if (bad[i] == 8'h57 || bad[i] == 8'h52) bad[i] = 8'h00;
    end
    for (int i = 0; i < 4; i++) begin
      clear_mon();
      send_byte(bad[i], e);
      wait_idle("nak");
      n_cmp++;
      if (err_n != 1) begin n_bad++; $display("FAIL nak_err: byte %h got %0d pulses required 1", bad[i], err_n); end
      n_cmp++;
      if (st_val_q.size() != 1 || st_val_q[0] !== 8'h15) begin
        n_bad++;
        $display("FAIL nak_resp: byte %h got %0d starts (first %h) required one 15", bad[i], st_val_q.size(),
                 st_val_q.size() > 0 ? st_val_q[0] : 8'hxx);
      end
      n_cmp++;
      if (we_addr_q.size() != 0) begin n_bad++; $display("FAIL nak_we: got %0d pulses required 0", we_addr_q.size()); end
      $display("nak   byte=%h", bad[i]);
    end
    do_read("rd_after_nak", 8'h00);
  endtask

  task automatic test_busy_hold();
    int e0, e1, ex, rel;
    logic [7:0] a;
    a = 8'($urandom_range(0, 255));
    do_write("hold_setup", a, 8'($urandom_range(0, 255)));
    clear_mon();
    hold_busy = 1'b1;
    send_byte(8'h52, e0);
    send_byte(a, e1);
    repeat (50) @(negedge clk);
    send_byte(8'($urandom_range(0, 255)), ex);
    repeat (50) @(negedge clk);
    n_cmp++;
    if (st_val_q.size() != 0) begin n_bad++; $display("FAIL hold_start: got %0d starts while busy, required 0", st_val_q.size()); end
    n_cmp++;
    if (err_n != 1) begin n_bad++; $display("FAIL hold_drop_err: got %0d pulses required 1", err_n); end
    n_cmp++;
    if (bus.busy_o !== 1'b1) begin n_bad++; $display("FAIL hold_busy_o: got %b required 1", bus.busy_o); end
    hold_busy = 1'b0;
    rel = cyc + 1;
    wait_idle("hold");
    n_cmp++;
    if (st_val_q.size() != 1) begin
      n_bad++;
      $display("FAIL hold_start_count: got %0d required 1", st_val_q.size());
    end else begin
      n_cmp++;
      if (st_cyc_q[0] != rel) begin n_bad++; $display("FAIL hold_release: start at cycle %0d required %0d", st_cyc_q[0], rel); end
      n_cmp++;
      if (st_val_q[0] !== ref_mem[a]) begin n_bad++; $display("FAIL hold_rdata: got %h required %h", st_val_q[0], ref_mem[a]); end
    end
    $display("hold  addr=%h released at cycle %0d", a, rel);
  endtask

  task automatic test_reset_mid();
    int e0, e1;
    do_write("rst_setup", 8'h20, 8'($urandom_range(1, 255)));
    clear_mon();
    send_byte(8'h57, e0);
    send_byte(8'h20, e1);
    n_cmp++;
    if (bus.addr_o !== 8'h20) begin n_bad++; $display("FAIL rst_pre_addr: got %h required 20", bus.addr_o); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy_o, bus.we_o, bus.start_tx_o, bus.err_o} !== 4'b0000 ||
        bus.addr_o !== '0 || bus.data_o !== 8'h00 || bus.serial_write_o !== 8'h00) begin
      n_bad++;
      $display("FAIL rst_async: busy=%b we=%b start=%b err=%b addr=%h data=%h txd=%h required all 0",
               bus.busy_o, bus.we_o, bus.start_tx_o, bus.err_o, bus.addr_o, bus.data_o, bus.serial_write_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    n_cmp++;
    if (st_val_q.size() != 0 || we_addr_q.size() != 0 || err_n != 0) begin
      n_bad++;
      $display("FAIL rst_discard: got starts=%0d we=%0d err=%0d required 0", st_val_q.size(), we_addr_q.size(), err_n);
    end
    $display("reset mid-packet done");
    do_read("rd_after_rst", 8'h20);
  endtask

  task automatic test_timeout();
    int e;
    clear_mon();
    send_byte(8'h57, e);
    repeat (20) @(negedge clk);
`ifdef UART_MEM_CTRL_TIMEOUT_EN
    n_cmp++;
    if (err_n != 1) begin n_bad++; $display("FAIL tmo_err: got %0d pulses required 1", err_n); end
    n_cmp++;
    if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL tmo_busy: got %b required 0", bus.busy_o); end
    n_cmp++;
    if (st_val_q.size() != 0 || we_addr_q.size() != 0) begin
      n_bad++;
      $display("FAIL tmo_quiet: got starts=%0d we=%0d required 0", st_val_q.size(), we_addr_q.size());
    end
    $display("timeout fired");
`else
    n_cmp++;
    if (bus.busy_o !== 1'b1) begin n_bad++; $display("FAIL notmo_busy: got %b required 1", bus.busy_o); end
    n_cmp++;
    if (err_n != 0 || st_val_q.size() != 0) begin
      n_bad++;
      $display("FAIL notmo_quiet: got err=%0d starts=%0d required 0", err_n, st_val_q.size());
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("no timeout, recovered by reset");
`endif
    do_read("rd_after_tmo", 8'h10);
  endtask

  task automatic test_back_to_back();
    logic [7:0] pool [8];
    for (int i = 0; i < 8; i++) pool[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 30; i++) begin
      logic [7:0] a;
      a = pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 1) == 1) do_write("b2b_wr", a, 8'($urandom_range(0, 255)));
      else                           do_read("b2b_rd", a);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_nak();
    test_busy_hold();
    test_reset_mid();
    test_timeout();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
